// File: rtl/glitch_free_counter_if.sv
// glitch_free_counter_if
//   Bundles the control inputs and registered outputs of glitch_free_counter.
//   The master modport belongs to whoever drives the counter. The slave modport
//   belongs to the counter itself.
//
//   en        count enable
//   up        direction, 1 = increment, 0 = decrement
//   load      synchronous load strobe (takes priority over en)
//   load_val  value to load; values >= MODULUS are clamped to MODULUS-1
//   clr_ovf   synchronous clear of the sticky wrap flag
//   count     binary count (registered)
//   gray      Gray code of count (registered)
//   tc        one-cycle wrap pulse (registered)
//   ovf       sticky wrap flag (registered)
interface glitch_free_counter_if #(
    parameter int WIDTH = 4
);
    logic             en;
    logic             up;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             clr_ovf;
    logic [WIDTH-1:0] count;
    logic [WIDTH-1:0] gray;
    logic             tc;
    logic             ovf;

    modport master (
        output en, up, load, load_val, clr_ovf,
        input  count, gray, tc, ovf
    );

    modport slave (
        input  en, up, load, load_val, clr_ovf,
        output count, gray, tc, ovf
    );
endinterface

// File: rtl/glitch_free_counter.sv
// glitch_free_counter
//   Modulo-MODULUS up/down counter. Every output comes straight from a flop,
//   so count, gray, tc and ovf cannot glitch between clock edges.
//   The Gray code is derived from the next count value and registered on the
//   same edge as count. As a result, gray always matches count, including
//   after a load or a reset.
//
//   Parameters
//     WIDTH    counter width in bits (>= 2)
//     MODULUS  count range 0..MODULUS-1 (2 <= MODULUS <= 2**WIDTH)
//
//   Ports
//     clk  rising-edge clock
//     rst  asynchronous, active-high reset; forces all outputs to 0 at once
//     bus  glitch_free_counter_if.slave (controls in, registered results out)
//
//   Per edge, the priority is load > en > hold.
module glitch_free_counter #(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    glitch_free_counter_if.slave  bus
);

    // MODULUS can be exactly 2**WIDTH, so the clamp compare uses one extra bit.
    localparam int               MAX_INT = MODULUS - 1;
    localparam logic [WIDTH:0]   MOD_EXT = MODULUS[WIDTH:0];
    localparam logic [WIDTH-1:0] MAX_VAL = MAX_INT[WIDTH-1:0];
    localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] count_reg, count_next;
    logic [WIDTH-1:0] gray_reg,  gray_next;
    logic             tc_reg,    tc_next;
    logic             ovf_reg,   ovf_next;
    logic             wrap;

    // Next count and wrap detection.
    // Wrap happens only on counting edges, never on a load.
    always_comb begin
        count_next = count_reg;
        wrap       = 1'b0;
        if (bus.load) begin
            if ({1'b0, bus.load_val} < MOD_EXT) begin
                count_next = bus.load_val;
            end else begin
                count_next = MAX_VAL;
            end
        end else if (bus.en) begin
            if (bus.up) begin
                if (count_reg == MAX_VAL) begin
                    count_next = '0;
                    wrap       = 1'b1;
                end else begin
                    count_next = count_reg + ONE;
                end
            end else begin
                if (count_reg == '0) begin
                    count_next = MAX_VAL;
                    wrap       = 1'b1;
                end else begin
                    count_next = count_reg - ONE;
                end
            end
        end
    end

    // Gray code of the next count: g[i] = c[i] ^ c[i+1], and the MSB passes through.
    generate
        for (genvar gi = 0; gi < WIDTH - 1; gi++) begin : g_gray
            assign gray_next[gi] = count_next[gi] ^ count_next[gi + 1];
        end
    endgenerate
    assign gray_next[WIDTH-1] = count_next[WIDTH-1];

    // tc marks exactly the cycle that shows the post-wrap value.
    // ovf is sticky; when a wrap and clr_ovf arrive on the same edge, the wrap wins.
    always_comb begin
        tc_next  = wrap;
        ovf_next = ovf_reg;
        if (bus.clr_ovf) begin
            ovf_next = 1'b0;
        end
        if (wrap) begin
            ovf_next = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg <= '0;
            gray_reg  <= '0;
            tc_reg    <= 1'b0;
            ovf_reg   <= 1'b0;
        end else begin
            count_reg <= count_next;
            gray_reg  <= gray_next;
            tc_reg    <= tc_next;
            ovf_reg   <= ovf_next;
        end
    end

    assign bus.count = count_reg;
    assign bus.gray  = gray_reg;
    assign bus.tc    = tc_reg;
    assign bus.ovf   = ovf_reg;

endmodule
